// File: rtl/fifo_stat.sv
// rtl/fifo_stat.sv - show-ahead FIFO with occupancy count, level thresholds and sticky error flags
module fifo_stat #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  input  logic         clr_err
);

  localparam int         DEPTH   = 2 ** W;
  localparam logic [W:0] DEPTH_C = (W + 1)'(DEPTH);
  localparam logic [W:0] AF_C    = (W + 1)'(AF_LVL);
  localparam logic [W:0] AE_C    = (W + 1)'(AE_LVL);

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic         run;
  logic         wr_ok;
  logic         rd_ok;
  logic [W:0]   count_nxt;

  // count_nxt already folds in reset/flush, so every status flag is one compare away
  always_comb begin
    run       = reset & ~flush;
    wr_ok     = run & wr & (~full | rd);
    rd_ok     = run & rd & ~empty;
    count_nxt = run ? count : '0;
    if (wr_ok && !rd_ok) begin
      count_nxt = count + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + 1'b1;
      if (rd_ok) r_ptr <= r_ptr + 1'b1;
      // a fresh error wins over a simultaneous clear
      overflow  <= (overflow & ~clr_err) | (wr & ~rd & full);
      underflow <= (underflow & ~clr_err) | (rd & empty);
    end
    count        <= count_nxt;
    empty        <= (count_nxt == '0);
    full         <= (count_nxt == DEPTH_C);
    almost_empty <= (count_nxt <= AE_C);
    almost_full  <= (count_nxt >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[w_ptr] <= w_data;
  end

  assign r_data = mem[r_ptr];

endmodule
